tile_query_arbiter: RTL and testbench
=====================================

Name: tile_query_arbiter

Overview:
- Shares one single-port synchronous tile RAM between up to NUM_REQ movement controllers: player on port 0, ghosts on ports 1..NUM_REQ-1.
- Each RAM word holds one tile: bit0 = wall, bit1 = dot. Requesters issue single-tile reads (wall/dot lookup) or writes (dot clear).
- Arbitrates round-robin at one grant per cycle, pipelines the RAM read latency, and returns each response tagged one-hot to its requester.
- Guards out-of-range tile indices so that underflow or overflow of neighbour lookups never reaches the RAM.

Parameters:
- NUM_REQ, 5, number of requester ports (2..8).
- TILE_COLS, 32, tiles per row.
- TILE_ROWS, 24, tiles per column.
- IDX_W, 10, tile index width; must satisfy 2^IDX_W >= TILE_COLS*TILE_ROWS.
- RD_LAT, 1, RAM read latency in cycles (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-port request pending.
- req_idx  in  NUM_REQ*IDX_W  per-port tile index; port i occupies bits [i*IDX_W +: IDX_W].
- req_we  in  NUM_REQ  per-port: 1 = write, 0 = read.
- req_wdata  in  NUM_REQ*2  per-port write data; port i occupies bits [i*2 +: 2].
- req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid and the pointer.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  2  response tile data {dot, wall}.
- rsp_oob  out  1  response belongs to an out-of-range request.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  IDX_W  RAM address.
- ram_wdata  out  2  RAM write data.
- ram_rdata  in  2  RAM read data, valid RD_LAT cycles after ram_en with ram_we = 0.

Behaviour:
- Reset (asynchronous, active-low) values: rr_ptr = 0; response pipeline cleared; rsp_valid = 0; rsp_data = 0; rsp_oob = 0. ram_en, ram_we, ram_addr and ram_wdata are 0 while reset is asserted.
- Handshake:
  - A requester holds req_valid, req_idx, req_we and req_wdata stable until it sees req_ready[i] = 1 on a clock edge.
  - A transfer occurs on a clock edge where req_valid[i] & req_ready[i] are both 1.
  - The requester may drop req_valid, or present a new request, in the following cycle.
- Arbitration:
  - At most one req_ready bit is high per cycle.
  - The winner is the first asserted req_valid found searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On a grant to port g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - With a single requester continuously valid, that requester is granted every cycle (full throughput).
- Issue, in the grant cycle (combinational):
  - If idx < TILE_COLS*TILE_ROWS: ram_en = 1, ram_we = req_we[g], ram_addr = idx, ram_wdata = req_wdata[g].
  - If idx is out of range: ram_en = 0 and no RAM access occurs.
- Response pipeline: a shift register of depth RD_LAT carries {one-hot id, we, oob}.
  - Exactly RD_LAT cycles after the grant, rsp_valid = id for one cycle.
  - Read, in range: rsp_data = ram_rdata, rsp_oob = 0.
  - Read, out of range: rsp_data = 2'b01 (treated as wall, no dot), rsp_oob = 1.
  - Write, in range: rsp_data = 2'b00, rsp_oob = 0; this is an acknowledge only.
  - Write, out of range: dropped with no RAM write; rsp_data = 2'b00, rsp_oob = 1.
- Back-to-back grants give one response per cycle, in grant order. There is no reordering and no backpressure on the response path; requesters must accept rsp_valid unconditionally.
- Read-after-write to the same index from any port, granted in a later cycle: returns the written data. The RAM is write-first or the accesses are sequential.
- Idle cycle: ram_en = 0; ram_addr and ram_wdata hold their last value (don't-care).
- Reset asserted mid-operation: all in-flight responses are discarded with no rsp_valid pulse; rr_ptr returns to 0.

Optional Feature:
- Macro: TILE_QUERY_PLAYER_PRIO_EN
- Defined:
  - Port 0 (player) wins whenever req_valid[0] = 1, regardless of rr_ptr.
  - Ports 1..NUM_REQ-1 are round-robin among themselves; rr_ptr only advances on their grants, and a port-0 grant leaves rr_ptr unchanged.
  - Starvation of the ghosts is acceptable by design.
- Undefined: plain round-robin over all ports, as described above.

Test Plan:
- Single read: reset, preload RAM[45] = 2'b10, port 0 reads idx 45 -> req_ready[0] in cycle 0; rsp_valid = 5'b00001, rsp_data = 2'b10, rsp_oob = 0 in cycle RD_LAT; ram_en high for exactly 1 cycle.
- Round-robin fairness: ports 0, 2, 4 held valid for 6 cycles -> grant sequence 0, 2, 4, 0, 2, 4; responses arrive in the same order, one per cycle.
- Out-of-range: port 1 reads idx 768 and port 3 reads idx 1023 (underflow of 0-1) -> no ram_en in those cycles; responses rsp_data = 2'b01 with rsp_oob = 1.
- Dot clear then read: port 0 writes idx 100 = 2'b00 (was 2'b10), then port 2 reads idx 100 -> write ack rsp_data = 0, then read rsp_data = 2'b00.
- Reset mid-flight with RD_LAT = 3: grant 3 reads, then assert reset for 1 cycle before the first response -> no rsp_valid ever appears; after release, port 0 is granted first.
- With TILE_QUERY_PLAYER_PRIO_EN: ports 0 and 1 both held valid for 4 cycles -> port 0 granted in all 4 cycles; port 1 granted in cycle 5 after port 0 drops req_valid.

Source files
------------

// File: rtl/tile_query_arbiter_if.sv
// Requester-side bus of the tile query arbiter: per-port request fields, one-hot
// grant and the shared, one-hot tagged response.
interface tile_query_arbiter_if #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = 10
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_idx;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ*2-1:0]     req_wdata;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [1:0]               rsp_data;
    logic                     rsp_oob;

    // Movement-controller side.
    modport master (
        output req_valid, req_idx, req_we, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_oob
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_idx, req_we, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_oob
    );
endinterface

// File: rtl/tile_query_arbiter.sv
// Shares one single-port synchronous tile RAM (bit0 = wall, bit1 = dot) between
// NUM_REQ movement controllers. One round-robin grant per cycle, out-of-range
// indices are kept off the RAM, and responses come back RD_LAT cycles later tagged
// one-hot to the requester.
// Optional feature: define TILE_QUERY_PLAYER_PRIO_EN to give port 0 (player)
// absolute priority over the ghosts.
module tile_query_arbiter #(
    parameter int unsigned NUM_REQ   = 5,
    parameter int unsigned TILE_COLS = 32,
    parameter int unsigned TILE_ROWS = 24,
    parameter int unsigned IDX_W     = 10,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    tile_query_arbiter_if.slave        bus,
    output logic                       ram_en,
    output logic                       ram_we,
    output logic [IDX_W-1:0]           ram_addr,
    output logic [1:0]                 ram_wdata,
    input  logic [1:0]                 ram_rdata
);
    localparam int unsigned PTR_W     = $clog2(NUM_REQ);
    localparam int unsigned NUM_TILES = TILE_COLS * TILE_ROWS;
`ifdef TILE_QUERY_PLAYER_PRIO_EN
    localparam bit PLAYER_PRIO = 1'b1;
`else
    localparam bit PLAYER_PRIO = 1'b0;
`endif

    typedef struct packed {
        logic [NUM_REQ-1:0] id;
        logic               we;
        logic               oob;
    } rsp_entry_t;

    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [PTR_W:0]     cand;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_we;
    logic [1:0]         sel_wdata;
    logic               sel_oob;
    logic [IDX_W-1:0]   addr_q;
    logic [1:0]         wdata_q;
    rsp_entry_t         pipe_q [RD_LAT];
    rsp_entry_t         rsp_tail;

    // Winner search from rr_ptr upward with wrap; the player may pre-empt it.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            // Under player priority port 0 is handled outside the ghost rotation.
            if (!grant_any && bus.req_valid[cand[PTR_W-1:0]] &&
                !(PLAYER_PRIO && cand == '0)) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (PLAYER_PRIO && bus.req_valid[0]) begin
            grant_any = 1'b1;
            grant_idx = '0;
        end
        // Nothing may transfer while reset is held.
        if (!reset) begin
            grant_any = 1'b0;
            grant_idx = '0;
        end
    end

    // Steer the winner's request fields and classify its index against the map size.
    always_comb begin
        grant_oh  = '0;
        sel_idx   = '0;
        sel_we    = 1'b0;
        sel_wdata = 2'b00;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_any && grant_idx == PTR_W'(i)) begin
                grant_oh[i] = 1'b1;
                sel_idx     = bus.req_idx[i*IDX_W +: IDX_W];
                sel_we      = bus.req_we[i];
                sel_wdata   = bus.req_wdata[i*2 +: 2];
            end
        end
        sel_oob = grant_any && (32'(sel_idx) >= NUM_TILES);
    end

    // RAM issue and grant; address/data hold their last value on idle cycles.
    always_comb begin
        ram_en        = grant_any && !sel_oob;
        ram_we        = ram_en && sel_we;
        ram_addr      = ram_en ? sel_idx : addr_q;
        ram_wdata     = ram_en ? sel_wdata : wdata_q;
        bus.req_ready = grant_oh;
    end

    // Pointer advance past the winner; a player-priority grant leaves it alone.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any && !(PLAYER_PRIO && grant_idx == '0)) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Arbiter pointer and held RAM address/data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (ram_en) begin
                addr_q  <= sel_idx;
                wdata_q <= sel_wdata;
            end
        end
    end

    // Response shift register matching the RAM read latency; reset drops in-flight entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            pipe_q[0] <= '{id: grant_oh, we: sel_we, oob: sel_oob};
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    // Response formatting: out-of-range reads look like walls, writes are bare acks.
    always_comb begin
        rsp_tail      = pipe_q[RD_LAT-1];
        bus.rsp_valid = rsp_tail.id;
        bus.rsp_oob   = rsp_tail.oob;
        bus.rsp_data  = 2'b00;
        if (|rsp_tail.id && !rsp_tail.we) begin
            bus.rsp_data = rsp_tail.oob ? 2'b01 : ram_rdata;
        end
    end
endmodule

// File: tb/tb_tile_query_arbiter.sv
// Directed bench for tile_query_arbiter with a write-first RAM model of latency RD_LAT.
module tb_tile_query_arbiter;
    localparam int unsigned NUM_REQ   = 5;
    localparam int unsigned TILE_COLS = 32;
    localparam int unsigned TILE_ROWS = 24;
    localparam int unsigned IDX_W     = 10;
    localparam int unsigned RD_LAT    = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ram_en;
    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [1:0]       ram_wdata;
    logic [1:0]       ram_rdata;
    int               n_cmp;
    int               n_fail;

    tile_query_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

    tile_query_arbiter #(
        .NUM_REQ(NUM_REQ), .TILE_COLS(TILE_COLS), .TILE_ROWS(TILE_ROWS),
        .IDX_W(IDX_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: write-first, read data emerges RD_LAT cycles after the access.
    logic [1:0]       mem [1024];
    logic [1:0]       rd_pipe [RD_LAT];
    logic             pl_en;
    logic [IDX_W-1:0] pl_addr;
    logic [1:0]       pl_data;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= (ram_en && ram_we) ? ram_wdata : mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_idx   = '0;
        bus.req_we    = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int p, input logic [IDX_W-1:0] idx, input logic we,
                           input logic [1:0] wd);
        bus.req_valid[p]             = 1'b1;
        bus.req_idx[p*IDX_W +: IDX_W] = idx;
        bus.req_we[p]                = we;
        bus.req_wdata[p*2 +: 2]       = wd;
    endtask

    task automatic apply_reset();
        clear_reqs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic preload(input logic [IDX_W-1:0] a, input logic [1:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        set_req(0, 10'd45, 1'b1, 2'b11);
        step();
        #1;
        n_cmp++; if (bus.rsp_valid !== 5'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00000", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_data: got %b want 00", bus.rsp_data); end
        n_cmp++; if (bus.rsp_oob !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_oob: got %b want 0", bus.rsp_oob); end
        n_cmp++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
        n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        n_cmp++; if (ram_addr !== 10'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
        n_cmp++; if (ram_wdata !== 2'b00) begin n_fail++; $display("FAIL reset_ram_wdata: got %b want 00", ram_wdata); end
        clear_reqs();
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int n_en = 0;
        apply_reset();
        preload(10'd45, 2'b10);
        for (int c = 0; c < RD_LAT + 2; c++) begin
            clear_reqs();
            if (c == 0) set_req(0, 10'd45, 1'b0, 2'b00);
            #1;
            if (ram_en === 1'b1) n_en++;
            if (c == 0) begin
                n_cmp++; if (bus.req_ready !== 5'b00001) begin n_fail++; $display("FAIL single_ready: got %b want 00001", bus.req_ready); end
                n_cmp++; if (ram_addr !== 10'd45 || ram_we !== 1'b0) begin n_fail++; $display("FAIL single_issue: got addr %0d we %b want 45 0", ram_addr, ram_we); end
            end
            if (c == RD_LAT) begin
                n_cmp++; if (bus.rsp_valid !== 5'b00001) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 00001", bus.rsp_valid); end
                n_cmp++; if (bus.rsp_data !== 2'b10 || bus.rsp_oob !== 1'b0) begin n_fail++; $display("FAIL single_rsp_data: got %b oob %b want 10 0", bus.rsp_data, bus.rsp_oob); end
            end else begin
                n_cmp++; if (bus.rsp_valid !== 5'b0) begin n_fail++; $display("FAIL single_rsp_quiet c%0d: got %b want 00000", c, bus.rsp_valid); end
            end
            step();
        end
        n_cmp++; if (n_en != 1) begin n_fail++; $display("FAIL single_ram_en_count: got %0d want 1", n_en); end
    endtask

    task automatic test_round_robin();
        int         exp_g [6] = '{0, 2, 4, 0, 2, 4};
        logic [1:0] pdata [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11};
        logic [4:0] one = 5'b00001;
        apply_reset();
        preload(10'd10, 2'b01);
        preload(10'd20, 2'b10);
        preload(10'd30, 2'b11);
        for (int c = 0; c < 6 + RD_LAT; c++) begin
            clear_reqs();
            if (c < 6) begin
                set_req(0, 10'd10, 1'b0, 2'b00);
                set_req(2, 10'd20, 1'b0, 2'b00);
                set_req(4, 10'd30, 1'b0, 2'b00);
            end
            #1;
            if (c < 6) begin
                n_cmp++; if (bus.req_ready !== (one << exp_g[c])) begin n_fail++; $display("FAIL rr_grant c%0d: got %b want %b", c, bus.req_ready, one << exp_g[c]); end
            end
            if (c >= RD_LAT) begin
                n_cmp++; if (bus.rsp_valid !== (one << exp_g[c-RD_LAT]) || bus.rsp_data !== pdata[exp_g[c-RD_LAT]]) begin
                    n_fail++; $display("FAIL rr_rsp c%0d: got %b/%b want %b/%b", c, bus.rsp_valid, bus.rsp_data, one << exp_g[c-RD_LAT], pdata[exp_g[c-RD_LAT]]);
                end
            end
            step();
        end
    endtask

    task automatic test_player_prio();
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            clear_reqs();
            if (c < 4) set_req(0, 10'd45, 1'b0, 2'b00);
            set_req(1, 10'd46, 1'b0, 2'b00);
            #1;
            if (c < 4) begin
                n_cmp++; if (bus.req_ready !== 5'b00001) begin n_fail++; $display("FAIL prio_player c%0d: got %b want 00001", c, bus.req_ready); end
            end else begin
                n_cmp++; if (bus.req_ready !== 5'b00010) begin n_fail++; $display("FAIL prio_ghost: got %b want 00010", bus.req_ready); end
            end
            step();
        end
        clear_reqs();
        for (int c = 0; c < RD_LAT + 1; c++) step();
    endtask

    task automatic test_out_of_range();
        apply_reset();
        for (int c = 0; c < RD_LAT + 3; c++) begin
            clear_reqs();
            if (c == 0) set_req(1, 10'd768, 1'b0, 2'b00);
            if (c <= 1) set_req(3, 10'd1023, 1'b0, 2'b00);
            if (c == 2) set_req(4, 10'd800, 1'b1, 2'b11);
            #1;
            if (c == 0) begin
                n_cmp++; if (bus.req_ready !== 5'b00010 || ram_en !== 1'b0) begin n_fail++; $display("FAIL oob_issue_768: got ready %b en %b want 00010 0", bus.req_ready, ram_en); end
            end
            if (c == 1) begin
                n_cmp++; if (bus.req_ready !== 5'b01000 || ram_en !== 1'b0) begin n_fail++; $display("FAIL oob_issue_1023: got ready %b en %b want 01000 0", bus.req_ready, ram_en); end
            end
            if (c == 2) begin
                n_cmp++; if (bus.req_ready !== 5'b10000 || ram_en !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL oob_issue_wr: got ready %b en %b we %b want 10000 0 0", bus.req_ready, ram_en, ram_we); end
            end
            if (c == RD_LAT) begin
                n_cmp++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_oob} !== {5'b00010, 2'b01, 1'b1}) begin n_fail++; $display("FAIL oob_rsp_768: got %b %b %b want 00010 01 1", bus.rsp_valid, bus.rsp_data, bus.rsp_oob); end
            end
            if (c == RD_LAT + 1) begin
                n_cmp++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_oob} !== {5'b01000, 2'b01, 1'b1}) begin n_fail++; $display("FAIL oob_rsp_1023: got %b %b %b want 01000 01 1", bus.rsp_valid, bus.rsp_data, bus.rsp_oob); end
            end
            if (c == RD_LAT + 2) begin
                n_cmp++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_oob} !== {5'b10000, 2'b00, 1'b1}) begin n_fail++; $display("FAIL oob_rsp_wr: got %b %b %b want 10000 00 1", bus.rsp_valid, bus.rsp_data, bus.rsp_oob); end
            end
            step();
        end
    endtask

    task automatic test_dot_clear();
        apply_reset();
        preload(10'd100, 2'b10);
        for (int c = 0; c < RD_LAT + 2; c++) begin
            clear_reqs();
            if (c == 0) set_req(0, 10'd100, 1'b1, 2'b00);
            if (c == 1) set_req(2, 10'd100, 1'b0, 2'b00);
            #1;
            if (c == 0) begin
                n_cmp++; if ({bus.req_ready, ram_en, ram_we, ram_addr, ram_wdata} !== {5'b00001, 1'b1, 1'b1, 10'd100, 2'b00}) begin
                    n_fail++; $display("FAIL clear_issue: got %b %b %b %0d %b want 00001 1 1 100 00", bus.req_ready, ram_en, ram_we, ram_addr, ram_wdata);
                end
            end
            if (c == 1) begin
                n_cmp++; if ({bus.req_ready, ram_en, ram_we, ram_addr} !== {5'b00100, 1'b1, 1'b0, 10'd100}) begin
                    n_fail++; $display("FAIL clear_read_issue: got %b %b %b %0d want 00100 1 0 100", bus.req_ready, ram_en, ram_we, ram_addr);
                end
            end
            if (c == RD_LAT) begin
                n_cmp++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_oob} !== {5'b00001, 2'b00, 1'b0}) begin n_fail++; $display("FAIL clear_ack: got %b %b %b want 00001 00 0", bus.rsp_valid, bus.rsp_data, bus.rsp_oob); end
            end
            if (c == RD_LAT + 1) begin
                n_cmp++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_oob} !== {5'b00100, 2'b00, 1'b0}) begin n_fail++; $display("FAIL clear_readback: got %b %b %b want 00100 00 0", bus.rsp_valid, bus.rsp_data, bus.rsp_oob); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_d [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
        apply_reset();
        for (int i = 0; i < 4; i++) preload(IDX_W'(200 + i), exp_d[i]);
        for (int c = 0; c < RD_LAT + 4; c++) begin
            clear_reqs();
            if (c < 4) set_req(3, IDX_W'(200 + c), 1'b0, 2'b00);
            #1;
            if (c < 4) begin
                n_cmp++; if (bus.req_ready !== 5'b01000 || ram_en !== 1'b1 || ram_addr !== IDX_W'(200 + c)) begin
                    n_fail++; $display("FAIL b2b_issue c%0d: got %b %b %0d want 01000 1 %0d", c, bus.req_ready, ram_en, ram_addr, 200 + c);
                end
            end
            if (c >= RD_LAT) begin
                n_cmp++; if (bus.rsp_valid !== 5'b01000 || bus.rsp_data !== exp_d[c-RD_LAT]) begin
                    n_fail++; $display("FAIL b2b_rsp c%0d: got %b %b want 01000 %b", c, bus.rsp_valid, bus.rsp_data, exp_d[c-RD_LAT]);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        int n_rsp = 0;
        apply_reset();
        set_req(1, 10'd10, 1'b0, 2'b00);
        set_req(2, 10'd20, 1'b0, 2'b00);
        set_req(3, 10'd30, 1'b0, 2'b00);
        #1;
        n_cmp++; if (bus.req_ready !== 5'b00010) begin n_fail++; $display("FAIL mid_grant0: got %b want 00010", bus.req_ready); end
        step();
        bus.req_valid[1] = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 5'b00100) begin n_fail++; $display("FAIL mid_grant1: got %b want 00100", bus.req_ready); end
        step();
        bus.req_valid[2] = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 5'b01000) begin n_fail++; $display("FAIL mid_grant2: got %b want 01000", bus.req_ready); end
        #1;
        reset = 1'b0;
        clear_reqs();
        step();
        n_cmp++; if (bus.rsp_valid !== 5'b0 || ram_en !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset: got rsp %b en %b want 00000 0", bus.rsp_valid, ram_en); end
        #3;
        reset = 1'b1;
        for (int c = 0; c < RD_LAT + 4; c++) begin
            step();
            if (bus.rsp_valid !== 5'b0) n_rsp++;
        end
        n_cmp++; if (n_rsp != 0) begin n_fail++; $display("FAIL mid_discard: got %0d response cycles want 0", n_rsp); end
        set_req(0, 10'd45, 1'b0, 2'b00);
        set_req(4, 10'd30, 1'b0, 2'b00);
        #1;
        n_cmp++; if (bus.req_ready !== 5'b00001) begin n_fail++; $display("FAIL mid_first_after: got %b want 00001", bus.req_ready); end
        step();
        bus.req_valid[0] = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 5'b10000) begin n_fail++; $display("FAIL mid_second_after: got %b want 10000", bus.req_ready); end
        step();
        clear_reqs();
        for (int c = 0; c < RD_LAT + 1; c++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = 2'b00;
        clear_reqs();
        test_reset();
        test_single_read();
`ifdef TILE_QUERY_PLAYER_PRIO_EN
        test_player_prio();
`else
        test_round_robin();
`endif
        test_out_of_range();
        test_dot_clear();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
